// File: rtl/dino_pkg.sv
// Shared definitions for the dino runner: game state encodings, screen
// geometry and default physics constants used by the controller and renderers.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int GROUND_Y = 400;

  localparam int DEF_JUMP_V0    = 12;
  localparam int DEF_GRAVITY    = 1;
  localparam int DEF_SCROLL_MAX = H_ACTIVE;
  localparam int DEF_SPEED_INIT = 2;
  localparam int DEF_SPEED_MAX  = 8;
  localparam int DEF_SCORE_DIV  = 6;
  localparam int DEF_DEAD_HOLD  = 30;

  function automatic logic [15:0] u16_max(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [15:0] u16_sat_inc(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

endpackage

// File: rtl/dino_game_ctrl_physics.sv
// Vertical jump physics for the dino: height above ground and signed velocity,
// stepped once per frame; standalone so the jump renderer can reuse it.
module dino_physics
  import dino_pkg::*;
#(
  parameter int JUMP_V0 = DEF_JUMP_V0,
  parameter int GRAVITY = DEF_GRAVITY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_launch,
  input  logic              i_step,
  output logic [9:0]        o_dino_h,
  output logic signed [5:0] o_vel
);

  logic [9:0]         r_h;
  logic signed [5:0]  r_vel;
  logic signed [11:0] w_h_sum;
  logic signed [7:0]  w_vel_dec;
  logic signed [5:0]  w_vel_next;

  always_comb begin
    w_h_sum    = $signed({2'b00, r_h}) + $signed({{6{r_vel[5]}}, r_vel});
    w_vel_dec  = {{2{r_vel[5]}}, r_vel} - 8'(GRAVITY);
    // Falling speed is clamped so the 6-bit velocity can never wrap positive.
    w_vel_next = (w_vel_dec < -8'sd31) ? -6'sd31 : w_vel_dec[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h   <= '0;
      r_vel <= '0;
    end else if (i_clear) begin
      r_h   <= '0;
      r_vel <= '0;
    end else if (i_step) begin
      if (w_h_sum <= 12'sd0) begin
        r_h   <= '0;
        r_vel <= '0;
      end else begin
        r_h   <= w_h_sum[9:0];
        r_vel <= w_vel_next;
      end
    end else if (i_launch) begin
      r_vel <= 6'(JUMP_V0);
    end
  end

  assign o_dino_h = r_h;
  assign o_vel    = r_vel;

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino runner game sequencer: IDLE/RUN/DEAD state machine, frame-tick driven
// scroll, speed ramp and scoring, with the jump physics in dino_physics.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int JUMP_V0    = DEF_JUMP_V0,
  parameter int GRAVITY    = DEF_GRAVITY,
  parameter int SCROLL_MAX = DEF_SCROLL_MAX,
  parameter int SPEED_INIT = DEF_SPEED_INIT,
  parameter int SPEED_MAX  = DEF_SPEED_MAX,
  parameter int SCORE_DIV  = DEF_SCORE_DIV,
  parameter int DEAD_HOLD  = DEF_DEAD_HOLD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        jump,
  input  logic        restart,
  input  logic        collision,
  output logic [1:0]  state,
  output logic [9:0]  dino_h,
  output logic [9:0]  scroll_x,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic        game_over
);

  localparam int DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int HOLD_W = $clog2(DEAD_HOLD + 1);

  logic              r_vs_s1, r_vs_s2, r_vs_s3;
  logic              r_tick;
  logic              r_jump_d, r_restart_d;
  logic              r_coll_lat;
  state_e            r_state;
  logic [9:0]        r_scroll;
  logic [3:0]        r_speed;
  logic [15:0]       r_score;
  logic [15:0]       r_hi;
  logic [DIV_W-1:0]  r_div;
  logic [HOLD_W-1:0] r_hold;
  logic              r_game_over;

  logic              w_jump_p, w_restart_p;
  logic              w_on_ground, w_dead_exit;
  logic              w_phys_clear, w_phys_launch, w_phys_step;
  logic [10:0]       w_scroll_sum;
  logic [9:0]        w_scroll_next;
  logic              w_div_wrap;
  logic [15:0]       w_score_next;
  logic [3:0]        w_speed_next;
  logic [9:0]        w_dino_h;
  logic signed [5:0] w_vel;

  // vsync is asynchronous to clk: two flops for metastability, a third for the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_s1     <= 1'b0;
      r_vs_s2     <= 1'b0;
      r_vs_s3     <= 1'b0;
      r_tick      <= 1'b0;
      r_jump_d    <= 1'b0;
      r_restart_d <= 1'b0;
      r_coll_lat  <= 1'b0;
    end else begin
      r_vs_s1     <= vsync;
      r_vs_s2     <= r_vs_s1;
      r_vs_s3     <= r_vs_s2;
      r_tick      <= r_vs_s2 & ~r_vs_s3;
      r_jump_d    <= jump;
      r_restart_d <= restart;
      if (r_tick)
        r_coll_lat <= collision;
      else if (collision)
        r_coll_lat <= 1'b1;
    end
  end

  always_comb begin
    w_jump_p      = jump & ~r_jump_d;
    w_restart_p   = restart & ~r_restart_d;
    w_on_ground   = (w_dino_h == 10'd0) && (w_vel == 6'sd0);
    w_dead_exit   = (r_state == ST_DEAD) && !r_tick && w_jump_p &&
                    (r_hold == HOLD_W'(DEAD_HOLD));
    w_phys_clear  = w_restart_p || w_dead_exit;
    w_phys_step   = !w_restart_p && (r_state == ST_RUN) && r_tick && !r_coll_lat;
    w_phys_launch = !w_restart_p && (r_state == ST_RUN) && !r_tick && w_jump_p && w_on_ground;

    w_scroll_sum  = {1'b0, r_scroll} + 11'(r_speed);
    w_scroll_next = (w_scroll_sum >= 11'(SCROLL_MAX)) ?
                    10'(w_scroll_sum - 11'(SCROLL_MAX)) : w_scroll_sum[9:0];

    w_div_wrap    = (r_div == DIV_W'(SCORE_DIV - 1));
    w_score_next  = w_div_wrap ? u16_sat_inc(r_score) : r_score;
    w_speed_next  = r_speed;
    // Speed steps up each time the low score byte rolls over.
    if ((w_score_next != r_score) && (w_score_next[7:0] == 8'd0) &&
        (r_speed < 4'(SPEED_MAX)))
      w_speed_next = r_speed + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_scroll    <= '0;
      r_speed     <= '0;
      r_score     <= '0;
      r_hi        <= '0;
      r_div       <= '0;
      r_hold      <= '0;
      r_game_over <= 1'b0;
    end else if (w_restart_p) begin
      r_state     <= ST_IDLE;
      r_scroll    <= '0;
      r_speed     <= '0;
      r_score     <= '0;
      r_div       <= '0;
      r_hold      <= '0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_jump_p) begin
            r_state <= ST_RUN;
            r_speed <= 4'(SPEED_INIT);
            r_score <= '0;
            r_div   <= '0;
            r_hold  <= '0;
          end
        end
        ST_RUN: begin
          if (r_tick) begin
            if (r_coll_lat) begin
              r_state     <= ST_DEAD;
              r_game_over <= 1'b1;
              r_hold      <= '0;
              r_hi        <= u16_max(r_hi, r_score);
            end else begin
              r_scroll <= w_scroll_next;
              r_div    <= w_div_wrap ? '0 : r_div + DIV_W'(1);
              r_score  <= w_score_next;
              r_speed  <= w_speed_next;
            end
          end
        end
        ST_DEAD: begin
          if (r_tick) begin
            if (r_hold != HOLD_W'(DEAD_HOLD))
              r_hold <= r_hold + HOLD_W'(1);
          end else if (w_dead_exit) begin
            r_state     <= ST_IDLE;
            r_scroll    <= '0;
            r_speed     <= '0;
            r_score     <= '0;
            r_div       <= '0;
            r_hold      <= '0;
            r_game_over <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dino_physics #(
    .JUMP_V0 (JUMP_V0),
    .GRAVITY (GRAVITY)
  ) u_physics (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_phys_clear),
    .i_launch (w_phys_launch),
    .i_step   (w_phys_step),
    .o_dino_h (w_dino_h),
    .o_vel    (w_vel)
  );

  assign state     = r_state;
  assign dino_h    = w_dino_h;
  assign scroll_x  = r_scroll;
  assign speed     = r_speed;
  assign score     = r_score;
  assign hi_score  = r_hi;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Self-checking bench for dino_game_ctrl: a frame-level game model compared
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_dino_game_ctrl;

  localparam int V0       = 12;
  localparam int SPD_INIT = 2;
  localparam int SPD_MAX  = 8;
  localparam int DIV      = 6;
  localparam int HOLD     = 30;
  localparam int WRAP     = 640;

  logic        clk = 1'b0;
  logic        rst_n, vsync, jump, restart, collision;
  logic [1:0]  state;
  logic [9:0]  dino_h, scroll_x;
  logic [3:0]  speed;
  logic [15:0] score, hi_score;
  logic        game_over;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Game model: 0 idle, 1 run, 2 dead
  int m_state = 0, m_h = 0, m_vel = 0, m_scroll = 0, m_speed = 0;
  int m_score = 0, m_hi = 0, m_div = 0, m_hold = 0;
  bit m_coll  = 0;

  int jtab [25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                    78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

  dino_game_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .jump      (jump),
    .restart   (restart),
    .collision (collision),
    .state     (state),
    .dino_h    (dino_h),
    .scroll_x  (scroll_x),
    .speed     (speed),
    .score     (score),
    .hi_score  (hi_score),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_state = 0; m_h = 0; m_vel = 0; m_scroll = 0; m_speed = 0;
    m_score = 0; m_div = 0; m_hold = 0;
  endtask

  task automatic m_jump();
    case (m_state)
      0: begin m_state = 1; m_speed = SPD_INIT; m_score = 0; m_div = 0; end
      1: if (m_h == 0 && m_vel == 0) m_vel = V0;
      2: if (m_hold == HOLD) m_clear();
      default: ;
    endcase
  endtask

  task automatic m_frame();
    if (m_state == 1) begin
      if (m_coll) begin
        m_state = 2;
        m_hold  = 0;
        if (m_score > m_hi) m_hi = m_score;
      end else begin
        if (m_h + m_vel <= 0) begin
          m_h = 0; m_vel = 0;
        end else begin
          m_h   = m_h + m_vel;
          m_vel = (m_vel - 1 < -31) ? -31 : m_vel - 1;
        end
        m_scroll = (m_scroll + m_speed) % WRAP;
        m_div++;
        if (m_div == DIV) begin
          m_div = 0;
          if (m_score < 65535) begin
            m_score++;
            if (m_score % 256 == 0 && m_speed < SPD_MAX) m_speed++;
          end
        end
      end
    end else if (m_state == 2 && m_hold < HOLD) begin
      m_hold++;
    end
    m_coll = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",     int'(state),     m_state);
      check("dino_h",    int'(dino_h),    m_h);
      check("scroll_x",  int'(scroll_x),  m_scroll);
      check("speed",     int'(speed),     m_speed);
      check("score",     int'(score),     m_score);
      check("hi_score",  int'(hi_score),  m_hi);
      check("game_over", int'(game_over), (m_state == 2) ? 1 : 0);
    end
  end

  // All stimulus tasks start and end just after a falling clock edge.
  task automatic frame();
    vsync = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(posedge clk);
    m_frame();
    @(negedge clk);
  endtask

  task automatic press_jump();
    jump = 1'b1;
    @(posedge clk);
    m_jump();
    @(negedge clk);
    jump = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_coll();
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    m_coll = 1;
  endtask

  task automatic restart_and_jump();
    restart = 1'b1;
    jump    = 1'b1;
    @(posedge clk);
    m_clear();
    @(negedge clk);
    restart = 1'b0;
    jump    = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, test did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b0; jump = 1'b0; restart = 1'b0; collision = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("lit_rst_state", int'(state), 0);
    check("lit_rst_score", int'(score), 0);
    check("lit_rst_go",    int'(game_over), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start a run and let 100 frames pass
    press_jump();
    check("lit_run_state", int'(state), 1);
    check("lit_run_speed", int'(speed), 2);
    repeat (100) frame();
    check("lit_100_score",  int'(score), 16);
    check("lit_100_scroll", int'(scroll_x), 200);
    check("lit_100_speed",  int'(speed), 2);
    repeat (219) frame();
    check("lit_scroll_638", int'(scroll_x), 638);
    frame();
    check("lit_scroll_wrap0", int'(scroll_x), 0);

    // Jump arc with an ignored airborne press after frame 5
    check("lit_ground", int'(dino_h), 0);
    press_jump();
    for (int f = 1; f <= 30; f++) begin
      frame();
      if (f <= 25) check($sformatf("lit_jump_h_f%0d", f), int'(dino_h), jtab[f-1]);
      if (f == 5) press_jump();
    end
    check("lit_jump_end", int'(dino_h), 0);

    // Speed ramp up to the ceiling
    for (int g = 0; g < 20000 && m_score < 256; g++) frame();
    check("lit_score_256", int'(score), 256);
    check("lit_speed_3",   int'(speed), 3);
    for (int g = 0; g < 20000 && m_score < 1536; g++) frame();
    check("lit_speed_8", int'(speed), 8);
    for (int g = 0; g < 20000 && m_score < 1792; g++) frame();
    check("lit_score_1792", int'(score), 1792);
    check("lit_speed_cap",  int'(speed), 8);

    // Collision in the same frame as a jump press
    press_jump();
    pulse_coll();
    frame();
    check("lit_dead_state", int'(state), 2);
    check("lit_dead_go",    int'(game_over), 1);
    check("lit_dead_h",     int'(dino_h), 0);
    check("lit_dead_hi",    int'(hi_score), 1792);
    repeat (10) frame();
    press_jump();
    check("lit_dead_early_jump", int'(state), 2);
    repeat (21) frame();
    press_jump();
    check("lit_dead_exit_state", int'(state), 0);
    check("lit_dead_exit_score", int'(score), 0);
    check("lit_dead_exit_hi",    int'(hi_score), 1792);

    // Restart and jump rising together during a run
    press_jump();
    repeat (20) frame();
    check("lit_pre_restart_score", int'(score), 3);
    restart_and_jump();
    check("lit_restart_state",  int'(state), 0);
    check("lit_restart_score",  int'(score), 0);
    check("lit_restart_scroll", int'(scroll_x), 0);
    check("lit_restart_hi",     int'(hi_score), 1792);

    // Asynchronous reset in the middle of a run
    press_jump();
    repeat (222) frame();
    check("lit_score_37", int'(score), 37);
    #2;
    rst_n = 1'b0;
    m_clear();
    m_hi = 0;
    m_coll = 0;
    #1;
    check("lit_arst_state",  int'(state), 0);
    check("lit_arst_score",  int'(score), 0);
    check("lit_arst_hi",     int'(hi_score), 0);
    check("lit_arst_scroll", int'(scroll_x), 0);
    check("lit_arst_speed",  int'(speed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) frame();
    check("lit_post_rst_state", int'(state), 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dino_game_ctrl.md
Name: dino_game_ctrl

Overview:
Central game sequencer for the dino runner.
- Owns the IDLE/RUN/DEAD game state machine.
- Runs the per-frame jump physics, ground scroll offset, speed ramp and score/hi-score counters.
- Sits between the debounced buttons and vga_controller vsync on the input side, and the ground/dino/pixel_gen renderers on the output side; replaces the ad-hoc state register in top.

Parameters:
JUMP_V0, 12, initial upward velocity in pixels/frame at jump start
GRAVITY, 1, velocity decrement per frame while airborne
SCROLL_MAX, 640, ground pattern period in pixels; scroll_x wraps modulo this
SPEED_INIT, 2, scroll pixels/frame at game start
SPEED_MAX, 8, speed ceiling
SCORE_DIV, 6, frames per score increment
DEAD_HOLD, 30, frames in DEAD before jump is accepted

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  reset; asynchronous, active-low
vsync  in  1  vga_controller vsync; active-low pulse, frame tick taken on its rising edge
jump  in  1  debounced jump button, level
restart  in  1  debounced restart button, level
collision  in  1  pixel-level overlap of dino and obstacle, valid during active video
state  out  2  00 IDLE, 01 RUN, 10 DEAD
dino_h  out  10  dino height above ground in pixels, 0 = on ground
scroll_x  out  10  ground horizontal offset, 0..SCROLL_MAX-1
speed  out  4  current scroll speed
score  out  16  current score, binary
hi_score  out  16  best score since reset
game_over  out  1  high in DEAD

Behaviour:
Reset:
- All outputs and internal registers clear to 0 (state IDLE).
- Reset is asynchronous; any frame in progress is abandoned.

Input conditioning:
- vsync is 2-flop synchronised; frame_tick is a single-cycle pulse on the synchronised rising edge, 3 clk after the pin rises.
- jump and restart are rising-edge detected on clk, giving jump_p and restart_p.
- collision sets a sticky coll_lat on any clk where it is high. coll_lat clears on frame_tick after being sampled.

Priority per clk: rst_n, then restart_p, then frame_tick logic, then jump_p.
- restart_p in any state: next cycle state=IDLE, dino_h=0, vel=0, scroll_x=0, speed=0, score=0. hi_score is kept.

IDLE:
- jump_p -> RUN next cycle; speed=SPEED_INIT, score=0, frame and score dividers cleared.

RUN:
- jump_p with dino_h==0 and vel==0: vel=JUMP_V0. A press while airborne is ignored, not buffered.
- On frame_tick, all updates land on the following cycle:
  - If coll_lat: state=DEAD, hi_score=max(hi_score, score). All other outputs freeze. Collision beats a same-frame jump or landing.
  - Else physics: vel is signed 6-bit. If dino_h+vel <= 0 then dino_h=0 and vel=0 (landing), else dino_h+=vel and vel-=GRAVITY. vel never goes below -31 (saturate).
  - scroll_x = scroll_x+speed, minus SCROLL_MAX if the sum >= SCROLL_MAX (exact wrap, no skipped value).
  - Frame divider counts 0..SCORE_DIV-1. On wrap, score+=1, saturating at 16'hFFFF.
  - When score[7:0] wraps to 0, speed+=1 up to SPEED_MAX.

DEAD:
- game_over=1; hold counter increments per frame_tick, saturating at DEAD_HOLD.
- jump_p with hold==DEAD_HOLD -> IDLE, with the same clears as restart. jump_p before that is ignored.

Decomposition:
- Shared package dino_pkg: state encodings ST_IDLE/ST_RUN/ST_DEAD, screen constants (H_ACTIVE=640, V_ACTIVE=480, GROUND_Y), default physics constants.
- Sub-module dino_physics holds the dino_h/vel update, so the jump renderer can reuse it standalone.
- Edge/sync logic stays inline.

Test Plan:
1. Reset low mid-RUN with score=37 -> all outputs 0 immediately, state=00.
2. IDLE, pulse jump, run 100 frames with collision=0 -> state=01; score=16 (100/6); scroll_x=200; speed=2.
3. RUN on ground, jump then 30 frame ticks -> dino_h sequence 12,23,33,... peaks at 78 at frame 12, returns to 0 by frame 25 with vel=0; a second jump at frame 5 is ignored.
4. Collision asserted 1 clk mid-frame, same frame as jump_p -> state=10 after next tick, dino_h frozen, hi_score=score. A jump at frame 10 of DEAD is ignored; jump at frame 31 -> IDLE.
5. Force speed=7, scroll_x=636 -> next tick scroll_x=3. Score reaching 256 -> speed increments; at SPEED_MAX stays 8.
6. restart and jump rising on the same clk in RUN -> IDLE, score=0, hi_score unchanged.
